regfile_arbiter: RTL
====================

# regfile_arbiter

Two-port round-robin arbiter that shares the 4x8 register file between the processor core (requester A) and the host/debug interface (requester B). It drives the register file's write port (`write`, `wr_select`, `data`) and read port 0 (`select0`, consuming `selected0`). Each requester sees a single-beat req/ack handshake. Read port 1 and the `register0`/`position`/`delay` taps stay wired directly to their consumers.

## Interface
- No parameters. Data width is fixed at 8 bits and address width at 2 bits, matching the register file.
- `clock` in 1: single clock, shared with the register file.
- `reset` in 1: synchronous, active-high. Top level drives register file `reset_n` = ~`reset`.
- `a_req` in 1: requester A transaction request; held until `a_ack`.
- `a_we` in 1: 1 = write, 0 = read. Sampled at grant.
- `a_addr` in 2: register index. Sampled at grant.
- `a_wdata` in 8: write data. Sampled at grant.
- `a_ack` out 1: one-cycle completion pulse.
- `a_rdata` out 8: read data, valid while `a_ack` is high after a read; otherwise holds its last value.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: requester B, same definitions as requester A.
- `b_err` out 1: pulses with `b_ack` when a B write is rejected. Constant 0 unless the write-protect macro is defined.
- `rf_write` out 1: to regfile `write`.
- `rf_wr_select` out 2: to regfile `wr_select`.
- `rf_data` out 8: to regfile `data`.
- `rf_select0` out 2: to regfile `select0`.
- `rf_selected0` in 8: from regfile `selected0` (registered in the regfile, one cycle after `select0`).

## Operation
- **Registered outputs.** All outputs are registered.
- **Reset values.** All outputs are 0. State is IDLE. `last_grant` = B, so A wins the first tie.
- **States.** IDLE, ISSUE, RDWAIT, DONE.
- **IDLE:**
  - If exactly one `req` is high, grant that requester.
  - If both are high, grant the requester that is not `last_grant`.
  - On grant, latch `we`/`addr`/`wdata` and the owner, update `last_grant`, and load `rf_select0`/`rf_wr_select`/`rf_data` from the latched request.
  - Set `rf_write` = `we` (forced 0 for a rejected B write).
  - Next state is ISSUE.
- **ISSUE:**
  - The regfile samples `rf_write` and `rf_select0` at the end of this cycle.
  - `rf_write` returns to 0 at the end of ISSUE, so it is high for exactly one cycle per write.
  - A write goes to DONE. A read goes to RDWAIT.
- **RDWAIT:** `rf_selected0` is valid this cycle. Capture it into the owner's `rdata`. Next state is DONE.
- **DONE:**
  - Owner's `ack` is high for this cycle only. For a rejected B write, `b_err` is also high.
  - Next state is IDLE.
- **Request sampling after ack.** IDLE samples `req` in the cycle after `ack`. A requester must drop `req` in that cycle, or it starts a new transaction.
- **Held outputs.** `rf_select0`, `rf_wr_select` and `rf_data` hold between transactions.
- **Non-owner isolation.** Non-owner `ack`/`rdata` are never disturbed.
- **Mid-transaction changes.** Changes to `req`/`we`/`addr`/`wdata` after grant are ignored until DONE. A requester dropping `req` early does not abort the transaction; `ack` still pulses.
- **Reset mid-transaction.**
  - The transaction is abandoned and no `ack` is issued.
  - `rf_write` is 0 from the next edge.
  - The regfile is cleared by its own reset.

## Timing
- **Write latency.** Request seen in IDLE at cycle 0. `rf_write` is high in cycle 1. The register is updated at the end of cycle 1. `ack` is high in cycle 2.
- **Read latency.** Request seen in IDLE at cycle 0. `rf_select0` is driven in cycle 1. `rf_selected0` is valid in cycle 2. `ack` and `rdata` are valid in cycle 3.
- **Throughput.** The minimum transaction spacing is 4 cycles for a read and 3 cycles for a write; IDLE takes one cycle between transactions.
- **Fairness.** With both requesters continuously requesting, grants alternate A, B, A, B. The worst-case wait for a requester is one other transaction.

## Configuration
- **`RFARB_B_WRITE_PROTECT_EN` defined:**
  - A B write to address 2 (`position`) or 3 (`delay`) is rejected.
  - `rf_write` stays 0 and the transaction still passes through ISSUE → DONE.
  - `b_ack` and `b_err` pulse together.
  - B writes to addresses 0 and 1, and all B reads, proceed normally.
- **Undefined:** B has the same access as A, and `b_err` is tied to 0.

## Test plan
- **Reset.** Assert `reset` for 2 cycles mid-read -> all outputs 0, no `ack` ever, next A request served normally, A wins first tie.
- **A write then read.** A writes 0x5A to addr 2 -> `rf_write` high for exactly 1 cycle with `rf_wr_select`=2, `rf_data`=0x5A, `a_ack` in cycle 2. Then A reads addr 2 -> `a_ack` in cycle 3 with `a_rdata`=0x5A.
- **Simultaneous requests.** A and B both request reads of addr 1 (preloaded 0x33) starting right after reset -> order is A, B, A, B. Each `rdata`=0x33. Non-owner `ack` stays 0 throughout.
- **Held request.** B holds `b_req` high through `b_ack` for a write of 0x07 to addr 1 -> a second identical write is issued. With `b_req` dropped in the cycle after `b_ack`, exactly one write occurs.
- **Write protect (`RFARB_B_WRITE_PROTECT_EN`).** B writes 0xFF to addr 3 -> `rf_write` never high, `b_ack` and `b_err` pulse together, `delay` unchanged. B writes 0x11 to addr 0 -> accepted with `b_err`=0. Without the macro, the addr 3 write succeeds with `b_err`=0.
- **Early drop.** A drops `a_req` in cycle 1 of a write -> the write still commits and `a_ack` still pulses in cycle 2.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Request/ack and register-file bus bundle for regfile_arbiter.
// slave = arbiter side, master = requesters plus register file.
interface regfile_arbiter_if;
  logic       a_req;
  logic       a_we;
  logic [1:0] a_addr;
  logic [7:0] a_wdata;
  logic       a_ack;
  logic [7:0] a_rdata;

  logic       b_req;
  logic       b_we;
  logic [1:0] b_addr;
  logic [7:0] b_wdata;
  logic       b_ack;
  logic [7:0] b_rdata;
  logic       b_err;

  logic       rf_write;
  logic [1:0] rf_wr_select;
  logic [7:0] rf_data;
  logic [1:0] rf_select0;
  logic [7:0] rf_selected0;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_err,
    output rf_write, rf_wr_select, rf_data,
    output rf_select0,
    input  rf_selected0
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_err,
    input  rf_write, rf_wr_select, rf_data,
    input  rf_select0,
    output rf_selected0
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the 4x8 register file between core (A) and host (B).
// Optional macro RFARB_B_WRITE_PROTECT_EN rejects B writes to addresses 2 and 3.
module regfile_arbiter (
  input  logic              clock,
  input  logic              reset,
  regfile_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic       own_q, own_d;
  logic       last_q, last_d;
  logic       we_q, we_d;
  logic       rej_q, rej_d;

  logic       a_ack_q, a_ack_d;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic       b_ack_q, b_ack_d;
  logic [7:0] b_rdata_q, b_rdata_d;
  logic       b_err_q, b_err_d;
  logic       rf_write_q, rf_write_d;
  logic [1:0] rf_wr_sel_q, rf_wr_sel_d;
  logic [7:0] rf_data_q, rf_data_d;
  logic [1:0] rf_sel0_q, rf_sel0_d;

  logic       gnt_a;
  logic       gnt_b;
  logic       b_wp;

  // own/last encoding: 0 = A, 1 = B
  assign gnt_a = bus.a_req & (~bus.b_req | last_q);
  assign gnt_b = bus.b_req & (~bus.a_req | ~last_q);

  // Protected B writes target position (2) and delay (3)
`ifdef RFARB_B_WRITE_PROTECT_EN
  assign b_wp = bus.b_we & bus.b_addr[1];
`else
  assign b_wp = 1'b0;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    last_d      = last_q;
    we_d        = we_q;
    rej_d       = rej_q;
    a_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_ack_d     = 1'b0;
    b_rdata_d   = b_rdata_q;
    b_err_d     = 1'b0;
    rf_write_d  = 1'b0;
    rf_wr_sel_d = rf_wr_sel_q;
    rf_data_d   = rf_data_q;
    rf_sel0_d   = rf_sel0_q;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          gnt_a: begin
            own_d       = 1'b0;
            last_d      = 1'b0;
            we_d        = bus.a_we;
            rej_d       = 1'b0;
            rf_write_d  = bus.a_we;
            rf_wr_sel_d = bus.a_addr;
            rf_sel0_d   = bus.a_addr;
            rf_data_d   = bus.a_wdata;
            state_d     = ISSUE;
          end
          gnt_b: begin
            own_d       = 1'b1;
            last_d      = 1'b1;
            we_d        = bus.b_we;
            rej_d       = b_wp;
            rf_write_d  = bus.b_we & ~b_wp;
            rf_wr_sel_d = bus.b_addr;
            rf_sel0_d   = bus.b_addr;
            rf_data_d   = bus.b_wdata;
            state_d     = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: begin
        if (we_q) begin
          a_ack_d = ~own_q;
          b_ack_d = own_q;
          b_err_d = own_q & rej_q;
          state_d = DONE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (own_q) begin
          b_rdata_d = bus.rf_selected0;
          b_ack_d   = 1'b1;
        end else begin
          a_rdata_d = bus.rf_selected0;
          a_ack_d   = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      own_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      rej_q       <= 1'b0;
      a_ack_q     <= 1'b0;
      a_rdata_q   <= 8'h00;
      b_ack_q     <= 1'b0;
      b_rdata_q   <= 8'h00;
      b_err_q     <= 1'b0;
      rf_write_q  <= 1'b0;
      rf_wr_sel_q <= 2'd0;
      rf_data_q   <= 8'h00;
      rf_sel0_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      last_q      <= last_d;
      we_q        <= we_d;
      rej_q       <= rej_d;
      a_ack_q     <= a_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_ack_q     <= b_ack_d;
      b_rdata_q   <= b_rdata_d;
      b_err_q     <= b_err_d;
      rf_write_q  <= rf_write_d;
      rf_wr_sel_q <= rf_wr_sel_d;
      rf_data_q   <= rf_data_d;
      rf_sel0_q   <= rf_sel0_d;
    end
  end

  assign bus.a_ack        = a_ack_q;
  assign bus.a_rdata      = a_rdata_q;
  assign bus.b_ack        = b_ack_q;
  assign bus.b_rdata      = b_rdata_q;
  assign bus.b_err        = b_err_q;
  assign bus.rf_write     = rf_write_q;
  assign bus.rf_wr_select = rf_wr_sel_q;
  assign bus.rf_data      = rf_data_q;
  assign bus.rf_select0   = rf_sel0_q;

endmodule
